// File: rtl/axis_exp_adc_responder_pkg.sv
// axis_exp_adc_responder_pkg: mode encodings, command words and FSM states shared by the responder.
// Rev 1.0
`default_nettype none

package axis_exp_adc_responder_pkg;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_REG  = 1'b1;

  localparam logic [23:0] EXIT_REG  = {1'b1, 15'h0014, 8'h01};
  localparam logic [23:0] ENTER_REG = {3'b101, 21'b0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CNV  = 2'd1,
    ST_REG  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/axis_exp_adc_responder_if.sv
// axis_exp_adc_responder_if: AXI Stream tdata/tvalid/tready bundle with master and slave views.
// Rev 1.0
`default_nettype none

interface axis_exp_adc_responder_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_exp_adc_responder_spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer for one SPI pin with rise/fall pulses on the synchronized level.
// Rev 1.0
`default_nettype none

module spi_sync_edge (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      level,
  output logic      rise,
  output logic      fall
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;
endmodule

`default_nettype wire

// File: rtl/axis_exp_adc_responder.sv
// axis_exp_adc_responder: SPI responder emulating a multi-lane ADC (conversion readout + register capture).
// Rev 1.0
`default_nettype none

module axis_exp_adc_responder
  import axis_exp_adc_responder_pkg::*;
#(
  parameter int NUM_SDI    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 24
) (
  input  wire logic                aclk,
  input  wire logic                aresetn,
  input  wire logic                spi_csn,
  input  wire logic                spi_sck,
  input  wire logic                spi_sdi,
  output logic [NUM_SDI-1:0]       spi_sdo,
  axis_exp_adc_responder_if.slave  s_axis,
  axis_exp_adc_responder_if.master m_axis,
  output logic                     reg_mode,
  output logic                     underrun,
  output logic                     overflow,
  output logic                     frame_error
);
  localparam logic [7:0]           REG_CNT  = 8'(REG_WIDTH);
  localparam logic [REG_WIDTH-1:0] ENTER_W  = REG_WIDTH'(ENTER_REG);
  localparam logic [REG_WIDTH-1:0] EXIT_W   = REG_WIDTH'(EXIT_REG);

  logic csn_lvl, csn_rise, csn_fall;
  logic sck_rise, sck_fall, sck_lvl_unused;
  logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

  spi_sync_edge u_csn (.clk(aclk), .rst_n(aresetn), .d(spi_csn),
                       .level(csn_lvl), .rise(csn_rise), .fall(csn_fall));
  spi_sync_edge u_sck (.clk(aclk), .rst_n(aresetn), .d(spi_sck),
                       .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge u_sdi (.clk(aclk), .rst_n(aresetn), .d(spi_sdi),
                       .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

  state_e                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   held_q, held_d;
  logic [REG_WIDTH-1:0]    rx_q, rx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_SDI-1:0]      sdo_q, sdo_d;
  logic                    tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    underrun_q, underrun_d;
  logic                    overflow_q, overflow_d;
  logic                    ferr_q, ferr_d;
  logic                    s_ready;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | csn_lvl;
    mode_d     = mode_q;
    shift_d    = shift_q;
    held_d     = held_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    tvalid_d   = tvalid_q & ~m_axis.tready;
    tdata_d    = tdata_q;
    underrun_d = 1'b0;
    overflow_d = 1'b0;
    ferr_d     = 1'b0;
    s_ready    = 1'b0;

    if (state_q != ST_IDLE && sck_rise) begin
      rx_d = {rx_q[REG_WIDTH-2:0], sdi_lvl};
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // armed_q keeps a CSn left low across reset from being taken as a frame start
        if (csn_fall && armed_q) begin
          rx_d  = '0;
          cnt_d = '0;
          if (mode_q == MODE_REG) begin
            state_d = ST_REG;
          end else begin
            state_d = ST_CNV;
            if (s_axis.tvalid) begin
              s_ready = 1'b1;
              shift_d = s_axis.tdata;
              held_d  = s_axis.tdata;
            end else begin
              shift_d    = held_q;
              underrun_d = 1'b1;
            end
          end
        end
      end
      ST_CNV: begin
        if (csn_rise) begin
          state_d = ST_IDLE;
          if (cnt_q == REG_CNT && rx_q == ENTER_W) mode_d = MODE_REG;
        end else if (sck_fall) begin
          shift_d = shift_q << NUM_SDI;
        end
      end
      ST_REG: begin
        if (csn_rise) begin
          state_d = ST_IDLE;
          if (cnt_q == REG_CNT) begin
            // a handshake in this same cycle frees the slot, so only a stalled word overflows
            if (tvalid_q && !m_axis.tready) begin
              overflow_d = 1'b1;
            end else begin
              tvalid_d = 1'b1;
              tdata_d  = DATA_WIDTH'(rx_q);
            end
            if (rx_q == EXIT_W) mode_d = MODE_CONV;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sdo_d = (state_d == ST_CNV) ? shift_d[DATA_WIDTH-1 -: NUM_SDI] : '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      mode_q     <= MODE_CONV;
      shift_q    <= '0;
      held_q     <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      sdo_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      mode_q     <= mode_d;
      shift_q    <= shift_d;
      held_q     <= held_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      sdo_q      <= sdo_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      ferr_q     <= ferr_d;
    end
  end

  assign spi_sdo       = sdo_q;
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign reg_mode      = mode_q;
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;
  assign frame_error   = ferr_q;
endmodule

`default_nettype wire

// File: tb/tb_axis_exp_adc_responder.sv
// tb_axis_exp_adc_responder: directed + randomized bench with a frame-level reference model.
// Rev 1.0
`default_nettype none

module tb_axis_exp_adc_responder;
  import axis_exp_adc_responder_pkg::*;

  localparam int NS     = 4;
  localparam int DW     = 32;
  localparam int RW     = 24;
  localparam int GROUPS = DW / NS;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          csn = 1'b1;
  logic          sck = 1'b0;
  logic          sdi = 1'b0;
  logic [NS-1:0] sdo;
  logic          reg_mode, underrun, overflow, frame_error;

  axis_exp_adc_responder_if #(.DATA_WIDTH(DW)) s_if ();
  axis_exp_adc_responder_if #(.DATA_WIDTH(DW)) m_if ();

  axis_exp_adc_responder #(.NUM_SDI(NS), .DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
    .aclk(aclk), .aresetn(aresetn), .spi_csn(csn), .spi_sck(sck), .spi_sdi(sdi),
    .spi_sdo(sdo), .s_axis(s_if), .m_axis(m_if), .reg_mode(reg_mode),
    .underrun(underrun), .overflow(overflow), .frame_error(frame_error)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Observed event counts, sampled on the falling edge away from DUT updates
  int n_underrun = 0, n_overflow = 0, n_ferr = 0, n_sready = 0;
  logic [DW-1:0] m_got[$];

  always @(negedge aclk) begin
    if (underrun)    n_underrun++;
    if (overflow)    n_overflow++;
    if (frame_error) n_ferr++;
    if (s_if.tvalid && s_if.tready) n_sready++;
    if (m_if.tvalid && m_if.tready) m_got.push_back(m_if.tdata);
  end

  // Reference model: frame-level view of the device
  logic          model_mode = 1'b0;
  logic [DW-1:0] model_last = '0;
  logic          m_pending  = 1'b0;
  logic [DW-1:0] exp_m[$];
  int exp_underrun = 0, exp_overflow = 0, exp_ferr = 0, exp_sready = 0;

  initial begin
    #2ms;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI frame at sck = aclk/8; reads spi_sdo just before each rising SCK edge
  task automatic spi_frame(input int nsck, input logic [31:0] word,
                           output logic [DW-1:0] rd, output logic tail_nz);
    rd = '0;
    tail_nz = 1'b0;
    csn = 1'b0;
    clk_wait(8);
    for (int i = 0; i < nsck; i++) begin
      sdi = word[nsck-1-i];
      clk_wait(4);
      if (i < GROUPS) rd = {rd[DW-NS-1:0], sdo};
      else if (sdo != '0) tail_nz = 1'b1;
      sck = 1'b1;
      clk_wait(4);
      sck = 1'b0;
    end
    clk_wait(6);
    csn = 1'b1;
    clk_wait(8);
  endtask

  task automatic do_cnv(input logic have, input logic [DW-1:0] smp, input int nsck,
                        input logic [31:0] word, input string tag);
    logic [DW-1:0] rd;
    logic          tnz;
    if (have) begin
      s_if.tdata  = smp;
      s_if.tvalid = 1'b1;
      model_last  = smp;
      exp_sready++;
    end else begin
      exp_underrun++;
    end
    spi_frame(nsck, word, rd, tnz);
    s_if.tvalid = 1'b0;
    if (nsck == RW && word[RW-1:0] == ENTER_REG) model_mode = 1'b1;
    if (nsck >= GROUPS) check({tag, "_data"}, rd, model_last);
    if (nsck > GROUPS)  check({tag, "_tail"}, tnz, 1'b0);
    check({tag, "_sready"}, n_sready, exp_sready);
    check({tag, "_underrun"}, n_underrun, exp_underrun);
    check({tag, "_mode"}, reg_mode, model_mode);
  endtask

  task automatic do_reg(input int nsck, input logic [31:0] word, input string tag);
    logic [DW-1:0] rd;
    logic          tnz;
    spi_frame(nsck, word, rd, tnz);
    if (nsck == RW) begin
      if (m_pending && !m_if.tready) begin
        exp_overflow++;
      end else begin
        exp_m.push_back(DW'(word[RW-1:0]));
        m_pending = !m_if.tready;
      end
      if (word[RW-1:0] == EXIT_REG) model_mode = 1'b0;
    end else begin
      exp_ferr++;
    end
    check({tag, "_sdo"}, sdo, '0);
    check({tag, "_mode"}, reg_mode, model_mode);
    check({tag, "_overflow"}, n_overflow, exp_overflow);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_tvalid"}, m_if.tvalid, m_pending);
    check({tag, "_mcount"}, m_got.size(), exp_m.size() - int'(m_pending));
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          tnz;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;

    clk_wait(4);
    check("rst_sdo", sdo, '0);
    check("rst_sready", s_if.tready, 1'b0);
    check("rst_mvalid", m_if.tvalid, 1'b0);
    check("rst_mdata", m_if.tdata, '0);
    check("rst_mode", reg_mode, 1'b0);
    check("rst_pulses", {underrun, overflow, frame_error}, 3'b000);
    aresetn = 1'b1;
    clk_wait(6);

    do_cnv(1'b1, 32'h89AB_CDEF, GROUPS, 32'h0, "cnv_fixed");
    for (int k = 0; k < 3; k++) do_cnv(1'b1, $urandom, GROUPS, $urandom, "cnv_rand");

    do_cnv(1'b0, '0, GROUPS, 32'h0, "underrun1");
    do_cnv(1'b0, '0, GROUPS, 32'h0, "underrun2");

    do_cnv(1'b1, $urandom, RW, $urandom & 32'h003F_FFFF, "cnv_long");
    do_cnv(1'b1, $urandom, RW, 32'(ENTER_REG), "enter");

    do_reg(RW, 32'h0000_1234, "write");
    check("write_tdata", m_if.tdata, 32'h0000_1234);
    clk_wait(20);
    check("write_hold_valid", m_if.tvalid, 1'b1);
    check("write_hold_tdata", m_if.tdata, 32'h0000_1234);

    do_reg(RW, $urandom & 32'h007F_FFFF, "overflow");
    check("overflow_keep", m_if.tdata, 32'h0000_1234);

    m_if.tready = 1'b1;
    m_pending   = 1'b0;
    clk_wait(3);
    check("drain_count", m_got.size(), 1);
    check("drain_data", m_got[0], 32'h0000_1234);
    check("drain_valid", m_if.tvalid, 1'b0);

    for (int k = 0; k < 3; k++) do_reg(RW, $urandom & 32'h007F_FFFF, "reg_rand");
    do_reg(10, $urandom, "short");
    do_reg(0, 32'h0, "glitch");
    do_reg(RW, 32'(EXIT_REG), "exit");

    check("m_total", m_got.size(), exp_m.size());
    for (int k = 0; k < exp_m.size() && k < m_got.size(); k++)
      check("m_word", m_got[k], exp_m[k]);

    // Reset in the middle of a conversion frame, CSn held low across release
    s_if.tdata  = $urandom;
    s_if.tvalid = 1'b1;
    exp_sready++;
    csn = 1'b0;
    clk_wait(8);
    for (int k = 0; k < 3; k++) begin
      clk_wait(4);
      sck = 1'b1;
      clk_wait(4);
      sck = 1'b0;
    end
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    model_last  = '0;
    model_mode  = 1'b0;
    clk_wait(2);
    check("mid_rst_sdo", sdo, '0);
    check("mid_rst_mode", reg_mode, 1'b0);
    check("mid_rst_mvalid", m_if.tvalid, 1'b0);
    aresetn = 1'b1;
    s_if.tdata  = $urandom;
    s_if.tvalid = 1'b1;
    clk_wait(12);
    check("mid_rst_wait_sdo", sdo, '0);
    check("mid_rst_wait_sready", n_sready, exp_sready);
    s_if.tvalid = 1'b0;
    csn = 1'b1;
    clk_wait(8);
    do_cnv(1'b0, '0, GROUPS, 32'h0, "post_rst_empty");
    do_cnv(1'b1, $urandom, GROUPS, 32'h0, "post_rst_cnv");
    check("post_rst_mcount", m_got.size(), exp_m.size());

    // unused variables from the frame task signature kept local
    rd  = '0;
    tnz = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/axis_exp_adc_responder.md
Name: axis_exp_adc_responder

Overview:
- Synthesizable SPI responder that emulates the external multi-lane ADC, for loopback and hardware-in-the-loop tests of the ADC controller.
- Conversion samples arrive on an AXI Stream input and are shifted out on NUM_SDI lanes while CSn is low.
- Register-access frames written by the controller are captured and forwarded on an AXI Stream output.
- SPI pins are oversampled in the aclk domain.

Parameters:
- NUM_SDI, 4, number of data lanes driven back to the controller; must divide DATA_WIDTH.
- DATA_WIDTH, 32, conversion word width and AXI Stream tdata width.
- REG_WIDTH, 24, register-access frame length in bits.

Ports:
- aclk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- spi_csn  in  1  chip select from controller, active low, asynchronous to aclk.
- spi_sck  in  1  SPI clock from controller, idle low.
- spi_sdi  in  1  serial data from controller (register writes), MSB first.
- spi_sdo  out  NUM_SDI  conversion data lanes to controller.
- s_axis_tdata  in  DATA_WIDTH  next conversion sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accepted.
- m_axis_tdata  out  DATA_WIDTH  captured register frame, zero-extended from REG_WIDTH.
- m_axis_tvalid  out  1  frame valid.
- m_axis_tready  in  1  downstream ready.
- reg_mode  out  1  1 = RegAccess mode, 0 = Conversion mode.
- underrun  out  1  one-cycle pulse: conversion frame started with no sample available.
- overflow  out  1  one-cycle pulse: register frame dropped because m_axis was still full.
- frame_error  out  1  one-cycle pulse: RegAccess frame ended with bit count other than REG_WIDTH.

Behaviour:
- Clock, reset and timing:
  - Single clock aclk. Reset is asynchronous, active-low on aresetn.
  - spi_sck frequency must be at most aclk/4.
  - spi_csn, spi_sck and spi_sdi each pass through a 2-FF synchronizer, then edge detection on the synchronized value.
- Reset values:
  - spi_sdo=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, reg_mode=0, all pulses 0.
  - Shift registers, bit counter and held sample are cleared.
- Reset mid-frame: the frame is abandoned with no m_axis output. After reset releases, the device waits for CSn to go high before it accepts a new frame.
- States: IDLE, CNV_FRAME, REG_FRAME.
- IDLE:
  - A synchronized CSn falling edge moves to CNV_FRAME if reg_mode=0, else to REG_FRAME.
  - SCK edges while CSn is high are ignored.
- CNV_FRAME entry (the same cycle the CSn fall is detected):
  - If s_axis_tvalid=1, assert s_axis_tready for exactly that cycle and load tdata into the output shift register.
  - Otherwise reload the last transmitted sample (0 after reset) and pulse underrun.
  - spi_sdo is updated in the next cycle to sample[DATA_WIDTH-1 -: NUM_SDI].
  - Latency from the raw CSn fall to valid spi_sdo: at most 4 aclk.
- CNV_FRAME shifting:
  - On each synchronized SCK falling edge, shift left by NUM_SDI; spi_sdo shows the next MSB group.
  - After DATA_WIDTH/NUM_SDI groups, spi_sdo holds 0.
- In both frame states:
  - On each synchronized SCK rising edge, shift spi_sdi into the receive register (MSB first).
  - The bit counter increments and saturates at 255.
- REG_FRAME: spi_sdo held 0.
- Frame end (synchronized CSn rising edge) returns to IDLE:
  - Conversion mode, count==REG_WIDTH, received word == EnterReg: set reg_mode=1.
  - Conversion mode, any other frame: no m_axis output.
  - RegAccess mode, count==REG_WIDTH: if m_axis_tvalid is already 1, pulse overflow and drop the word; else drive m_axis_tdata={0,word} and m_axis_tvalid=1.
  - RegAccess mode, word == ExitReg: clear reg_mode. The exit word is still forwarded on m_axis (subject to the overflow rule).
  - RegAccess mode, count != REG_WIDTH: pulse frame_error; no output; mode unchanged.
- m_axis handshake:
  - tvalid stays high until tvalid&tready; tdata is stable while tvalid is high.
  - A new capture in the same cycle as a handshake is accepted: no overflow, tvalid stays 1 with the new data.
- Spurious CSn glitch (fall and rise with zero SCK edges):
  - Conversion mode: still consumes a sample.
  - RegAccess mode: pulses frame_error.

Decomposition:
- Shared include exp_adc_defs.vh holds:
  - mode encodings Conversion=0 / RegAccess=1;
  - ExitReg = {1'b1, 15'h0014, 8'h01};
  - EnterReg = {3'b101, 21'b0}.
- The ADC controller includes the same file.
- One sub-module, spi_sync_edge: 2-FF synchronizer with rise/fall pulse outputs, instantiated for csn, sck and sdi (sdi uses level only).

Test Plan:
- Conversion read: push 32'h89AB_CDEF, drop CSn, 8 SCK cycles at aclk/8 → spi_sdo reads 4'h8,9,A,B,C,D,E,F on successive rising edges; s_axis_tready pulses once; no underrun.
- Underrun: empty s_axis, run two conversion frames after the first sample → both frames return the previous sample; underrun pulses once per frame; reset then an empty frame → all zeros.
- Enter and write: 24-bit frame 24'hA00000 → reg_mode=1. Next frame 24'h001234 → m_axis_tdata=32'h0000_1234, tvalid held high until tready.
- Overflow and exit: with m_axis_tready=0, send two REG frames → second frame pulses overflow; first word retained. Then tready=1 and send ExitReg → exit word forwarded, reg_mode=0.
- Short frame: in RegAccess mode, raise CSn after 10 SCK edges → frame_error pulse, no m_axis_tvalid, reg_mode stays 1.
- Reset mid-frame: assert aresetn=0 after 3 SCK edges of a conversion frame → spi_sdo=0, reg_mode=0, no tvalid. A new frame after CSn goes high works normally.
